// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-read-port instruction memory between the
// fetch stage and a data-side read port (constant pools, jump tables).
// One grant per cycle with a 0-cycle grant path. Read data is routed back to
// the winner exactly one cycle after its grant.
// Optional build macro IMEM_ARB_RR_EN: two-way round-robin replaces
// data-priority arbitration with the fetch starvation counter.
module imem_arbiter #(
  parameter int IDX_W      = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_req,
  input  logic [31:0]      f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [31:0]      f_rdata,
  input  logic             d_req,
  input  logic [31:0]      d_addr,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_err,
  output logic             mem_en,
  output logic [IDX_W-1:0] mem_idx,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_t;

  owner_t owner_q, owner_d;
  logic   err_q, err_d;
  logic   d_misal;
  logic   f_win;

  // Address bits outside the word index only alias; fetch byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[1:0], f_addr[31:IDX_W+2], d_addr[31:IDX_W+2]};

  assign d_misal = (d_addr[1:0] != 2'b00);

`ifdef IMEM_ARB_RR_EN
  logic fav_f;  // 1: fetch wins the next contended cycle

  logic unused_starve;
  assign unused_starve = (STARVE_MAX > 0);

  // Fetch wins when alone or when it holds the round-robin favour.
  always_comb begin
    f_win = f_req && (!d_req || fav_f);
  end

  // Flip favour after every contended cycle (a grant always happens then).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                fav_f <= 1'b1;
    else if (f_req && d_req) fav_f <= !fav_f;
  end
`else
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  // Data has priority unless fetch has been denied STARVE_MAX cycles in a row.
  always_comb begin
    f_win = f_req && (!d_req || (starve_cnt == CNT_MAX));
  end

  // Count consecutive denied fetch cycles, saturating at STARVE_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               starve_cnt <= '0;
    else if (!f_req || f_gnt)              starve_cnt <= '0;
    else if (starve_cnt != CNT_MAX)        starve_cnt <= starve_cnt + CNT_W'(1);
  end
`endif

  // Grants, memory request and next owner tag for the current cycle.
  always_comb begin
    f_gnt   = !rst && f_win;
    d_gnt   = !rst && d_req && !f_win;
    mem_en  = f_gnt || (d_gnt && !d_misal);
    mem_idx = '0;
    owner_d = OWN_NONE;
    err_d   = 1'b0;
    if (f_gnt) begin
      mem_idx = f_addr[IDX_W+1:2];
      owner_d = OWN_F;
    end else if (d_gnt) begin
      mem_idx = d_addr[IDX_W+1:2];
      owner_d = OWN_D;
      err_d   = d_misal;
    end
  end

  // Owner tag and error flag of the response due next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Route the synchronous read data to the owner only; errors return zero.
  always_comb begin
    f_rvalid = (owner_q == OWN_F);
    d_rvalid = (owner_q == OWN_D);
    d_err    = d_rvalid && err_q;
    f_rdata  = f_rvalid ? mem_rdata : 32'h0;
    d_rdata  = (d_rvalid && !err_q) ? mem_rdata : 32'h0;
  end

endmodule
